// File: rtl/pc_predict_pkg.sv
// Shared constants and types for the fetch-address predictor: table geometry,
// address field positions, counter encodings and the saturating counter step.
package pc_predict_pkg;

  localparam int BhtNum = 64;
  localparam int IdxHi  = 7;
  localparam int IdxLo  = 2;
  localparam int TagHi  = 31;
  localparam int TagLo  = 8;
  localparam int IdxW   = IdxHi - IdxLo + 1;
  localparam int TagW   = TagHi - TagLo + 1;

  localparam logic [1:0] StrongNT = 2'b00;
  localparam logic [1:0] WeakNT   = 2'b01;
  localparam logic [1:0] WeakT    = 2'b10;
  localparam logic [1:0] StrongT  = 2'b11;

  localparam logic [31:0] PcInc = 32'd4;

  typedef struct packed {
    logic            valid;
    logic [TagW-1:0] tag;
    logic [31:0]     target;
    logic [1:0]      ctr;
  } bht_entry_t;

  // Two-bit saturating counter: up on taken, down on not-taken.
  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
    logic [1:0] r;
    r = c;
    if (up && c != StrongT) r = c + 2'd1;
    if (!up && c != StrongNT) r = c - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/pc_predict_bpu_table.sv
// Direct-mapped branch target table: combinational lookup on the fetch pc,
// registered update from resolved branches (visible from the next cycle).
module bpu_table
  import pc_predict_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] lookup_pc,
  output logic        hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd,
  input  logic [31:2] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  bht_entry_t tbl [BhtNum];

  logic [IdxW-1:0] lidx;
  logic [IdxW-1:0] uidx;
  bht_entry_t      lent;
  bht_entry_t      uent;
  logic            uhit;

  always_comb begin
    lidx        = lookup_pc[IdxHi:IdxLo];
    lent        = tbl[lidx];
    hit         = lent.valid && (lent.tag == lookup_pc[TagHi:TagLo]);
    pred_taken  = lent.ctr[1];
    pred_target = lent.target;
  end

  always_comb begin
    uidx = upd_pc[IdxHi:IdxLo];
    uent = tbl[uidx];
    uhit = uent.valid && (uent.tag == upd_pc[TagHi:TagLo]);
  end

  // Only valid and ctr are reset; tag/target are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BhtNum; i++) begin
        tbl[i].valid <= 1'b0;
        tbl[i].ctr   <= WeakNT;
      end
    end else if (upd) begin
      if (uhit) begin
        tbl[uidx].ctr <= ctr_step(uent.ctr, upd_taken);
        if (upd_taken) tbl[uidx].target <= upd_target;
      end else if (upd_taken) begin
        tbl[uidx].valid  <= 1'b1;
        tbl[uidx].tag    <= upd_pc[TagHi:TagLo];
        tbl[uidx].target <= upd_target;
        tbl[uidx].ctr    <= WeakT;
      end
    end
  end

endmodule

// File: rtl/pc_predict.sv
// Fetch pc generator: holds pc/ce and picks the next fetch address from
// flush, mispredict recovery, stall, or the table's prediction.
module pc_predict
  import pc_predict_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        mispredict,
  input  logic [31:0] correct_pc,
  input  logic        br_update,
  input  logic [31:0] br_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] pc,
  output logic        ce,
  output logic        isTaken
);

  logic        hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] next_pc;

  bpu_table u_table (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc  (pc[31:2]),
    .hit        (hit),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .upd        (br_update),
    .upd_pc     (br_pc[31:2]),
    .upd_taken  (br_taken),
    .upd_target (br_target)
  );

  assign isTaken = ce & hit & pred_taken;

  always_comb begin
    next_pc = isTaken ? pred_target : pc + PcInc;
    if (stall)      next_pc = pc;
    if (mispredict) next_pc = correct_pc;
    if (flush)      next_pc = new_pc;
  end

  // ce goes high one edge before pc moves, so address 0 is fetched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= 32'h0;
      ce <= 1'b0;
    end else begin
      ce <= 1'b1;
      if (ce) pc <= next_pc;
    end
  end

endmodule

// File: doc/pc_predict.md
PC_PREDICT -- requirements
Module: pc_predict

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port stall, input, 1 bit: hold pc when 1.
REQ-004 SHALL have port flush, input, 1 bit: exception or redirect request.
REQ-005 SHALL have port new_pc, input, `InstAddrBus: flush target.
REQ-006 SHALL have port mispredict, input, 1 bit: the EX stage found the fetched path wrong.
REQ-007 SHALL have port correct_pc, input, `InstAddrBus: recovery address used on mispredict.
REQ-008 SHALL have port br_update, input, 1 bit: a resolved branch is reported this cycle.
REQ-009 SHALL have port br_pc, input, `InstAddrBus: address of the resolved branch.
REQ-010 SHALL have port br_taken, input, 1 bit: actual outcome of the resolved branch.
REQ-011 SHALL have port br_target, input, `InstAddrBus: actual taken target.
REQ-012 SHALL have port pc, output reg, `InstAddrBus: fetch address sent to instruction ROM addr.
REQ-013 SHALL have port ce, output reg, 1 bit: fetch enable sent to instruction ROM ce.
REQ-014 SHALL have port isTaken, output, 1 bit: prediction for pc, sent to instruction ROM input_isTaken.

Function
REQ-015 SHALL hold a 64-entry direct-mapped predictor table indexed by pc[7:2].
REQ-016 SHALL store per entry: valid, tag = pc[31:8], 32-bit target, 2-bit saturating counter.
REQ-017 SHALL compute hit = valid & tag match on the current pc, combinationally.
REQ-018 SHALL drive isTaken = ce & hit & counter[1], combinationally; there is no extra latency.
REQ-019 SHALL compute the predicted next pc as: entry target if isTaken, else pc+4 with 32-bit wrap (0xFFFFFFFC -> 0x00000000).
REQ-020 SHALL apply next-pc priority on each edge while ce=1, highest first: flush -> new_pc; mispredict -> correct_pc; stall -> hold pc; otherwise predicted next pc.
REQ-021 SHALL register ce as 1 on every edge with rst=0; pc SHALL NOT advance on the first edge after reset, so address 0x00000000 is fetched first.
REQ-022 SHALL apply flush and mispredict even when stall=1.
REQ-023 SHALL, on br_update with a hit at br_pc[7:2], increment the counter (saturate at 2'b11) if br_taken, else decrement it (saturate at 2'b00), and rewrite the target when br_taken.
REQ-024 SHALL, on br_update with a miss and br_taken=1, allocate the entry: valid=1, tag=br_pc[31:8], target=br_target, counter=2'b10, replacing any prior entry.
REQ-025 SHALL, on br_update with a miss and br_taken=0, leave the table unchanged.
REQ-026 SHALL make table writes visible from the next cycle only; a same-cycle lookup at the written index uses the old contents.
REQ-027 SHALL perform table updates regardless of stall, flush or mispredict.

Reset
REQ-028 SHALL, while rst=1, set pc=0x00000000 and ce=0, hold isTaken=0, clear every valid bit and set every counter to 2'b01.
REQ-029 SHALL let reset asserted mid-operation override all other inputs on that edge, including br_update.

Structure
REQ-030 SHALL place BhtNum (64), BhtIndexBus (7:2), BhtTagBus (31:8), counter encodings (StrongNT 2'b00 .. StrongT 2'b11) and PcInc (4) in defines.v.
REQ-031 SHALL implement the table, its lookup and its update as one sub-module, bpu_table; pc_predict holds the pc/ce registers and next-pc selection.

Verification
REQ-032 SHALL cover: reset, then release with no other inputs -> pc sequence 0x0, 0x0, 0x4, 0x8; ce 0 during reset, then 1; isTaken 0.
REQ-033 SHALL cover: br_update with br_pc=0x10, br_taken=1, br_target=0x40, then fetch reaching 0x10 -> isTaken=1 at pc 0x10, next pc 0x40.
REQ-034 SHALL cover: two not-taken updates on the entry from REQ-033 -> counter 10->01->00; the next fetch at 0x10 gives isTaken=0 and next pc 0x14; a further not-taken update leaves the counter at 00.
REQ-035 SHALL cover: stall=1 and mispredict=1 (correct_pc=0x200) on the same edge -> pc=0x200; flush=1 (new_pc=0x8) together with mispredict -> pc=0x8.
REQ-036 SHALL cover: 0x110 is allocated, then fetch reaches 0x10 (same index, different tag) -> miss and isTaken=0; br_update at the index currently being looked up -> the old prediction is used that cycle and the new one the next cycle.
REQ-037 SHALL cover: rst raised mid-stream after the table is trained -> the table is invalidated, and the fetch at 0x10 after reset gives isTaken=0.
